// File: rtl/if_fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// if_fetch_ctrl_if
//  Bundles every signal between the fetch controller, the PC stage, the
//  instruction sources and the IF/ID register. The controller connects
//  through the master modport. The surrounding pipeline/memories (or a
//  testbench) connect through the slave modport.
//
//  pc         PC stage -> ctrl   fetch address, valid every cycle
//  stall      hazard   -> ctrl   pipeline stall
//  src_re     ctrl -> sources    one-hot read enable per source
//  src_rdata  sources -> ctrl    packed read data, source i at [i*DATA_W +: DATA_W]
//  src_ready  sources -> ctrl    per-source data valid
//  instr      ctrl -> IF/ID      fetched instruction (NOP when none)
//  instr_vld  ctrl -> IF/ID      instr is a real fetched instruction
//  fetch_wait ctrl -> PC stage   controller busy, hold the PC
//  fault      ctrl -> trap       one-cycle pulse for an unmapped PC
//  fault_pc   ctrl -> trap       PC of the most recent fault
// ---------------------------------------------------------------------------
interface if_fetch_ctrl_if #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int NUM_SRC = 2
);
   logic [ADDR_W-1:0]         pc;
   logic                      stall;
   logic [NUM_SRC-1:0]        src_re;
   logic [NUM_SRC*DATA_W-1:0] src_rdata;
   logic [NUM_SRC-1:0]        src_ready;
   logic [DATA_W-1:0]         instr;
   logic                      instr_vld;
   logic                      fetch_wait;
   logic                      fault;
   logic [ADDR_W-1:0]         fault_pc;

   modport master (
      input  pc, stall, src_rdata, src_ready,
      output src_re, instr, instr_vld, fetch_wait, fault, fault_pc
   );

   modport slave (
      output pc, stall, src_rdata, src_ready,
      input  src_re, instr, instr_vld, fetch_wait, fault, fault_pc
   );
endinterface

// File: rtl/if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// if_fetch_ctrl
//  Instruction-fetch controller between the PC stage and NUM_SRC
//  synchronous-read instruction sources. The top TAG_W bits of the PC
//  select a source. That source's read enable is raised in the request
//  cycle, and its data is returned to IF/ID one cycle later. The data can
//  arrive later if the source holds src_ready low, in which case the
//  controller waits for it. A stall parks the last delivered instruction in
//  a hold register. An unmapped PC produces a one-cycle fault pulse and
//  records the offending PC.
//
//  clk    clock
//  reset  synchronous, active-high reset
//  bus    if_fetch_ctrl_if.master: pc, stall, src_re, src_rdata, src_ready,
//         instr, instr_vld, fetch_wait, fault, fault_pc
// ---------------------------------------------------------------------------
module if_fetch_ctrl #(
   parameter int                       ADDR_W    = 32,
   parameter int                       DATA_W    = 32,
   parameter int                       NUM_SRC   = 2,
   parameter int                       TAG_W     = 4,
   parameter logic [NUM_SRC*TAG_W-1:0] SRC_TAGS  = 8'h41,
   parameter logic [DATA_W-1:0]        NOP_INSTR = '0
) (
   input  logic           clk,
   input  logic           reset,
   if_fetch_ctrl_if.master bus
);

   localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   typedef enum logic {ST_RUN, ST_WAIT} state_t;

   state_t              state_q, state_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic                pend_q, pend_d;
   logic                fault_q, fault_d;
   logic [ADDR_W-1:0]   fault_pc_q, fault_pc_d;
   logic [DATA_W-1:0]   hold_q, hold_d;
   logic                hold_vld_q, hold_vld_d;

   logic [TAG_W-1:0]    tag;
   logic                hit;
   logic [SEL_W-1:0]    hit_idx;
   logic                sel_ready;
   logic [DATA_W-1:0]   sel_data;
   logic                outstanding;
   logic [NUM_SRC-1:0]  re_c;
   logic [DATA_W-1:0]   instr_c;
   logic                vld_c;
   logic                wait_c;

   // Tag decode. The loop scans from the highest index down so that the
   // lowest matching index is the last one written and therefore wins.
   always_comb begin
      tag     = bus.pc[ADDR_W-1 -: TAG_W];
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (tag == SRC_TAGS[i*TAG_W +: TAG_W]) begin
            hit     = 1'b1;
            hit_idx = SEL_W'(i);
         end
      end
   end

   // Read-back path for the source registered by the previous request.
   always_comb begin
      sel_ready = bus.src_ready[sel_q];
      sel_data  = bus.src_rdata[int'(sel_q)*DATA_W +: DATA_W];
   end

   // Next-state and output logic.
   // A request is outstanding in the cycle after a RUN issue, and for the
   // whole of WAIT. While it is outstanding and the source is not ready,
   // the controller keeps the enable up and asks the CPU to hold the PC.
   // No new decode happens in that case. The hold register has priority
   // on the instruction output, so a stalled pipeline keeps seeing the
   // instruction it already received.
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      pend_d     = 1'b0;
      fault_d    = 1'b0;
      fault_pc_d = fault_pc_q;
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      re_c       = '0;
      instr_c    = NOP_INSTR;
      vld_c      = 1'b0;

      outstanding = (state_q == ST_WAIT) || pend_q;
      wait_c      = outstanding && !sel_ready;

      if (hold_vld_q) begin
         instr_c = hold_q;
         vld_c   = 1'b1;
      end else if (outstanding && sel_ready) begin
         instr_c = sel_data;
         vld_c   = 1'b1;
      end

      case (state_q)
         ST_WAIT: begin
            re_c[sel_q] = 1'b1;
            if (sel_ready) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            if (wait_c) begin
               re_c[sel_q] = 1'b1;
               state_d     = ST_WAIT;
            end else if (!bus.stall) begin
               if (hit) begin
                  re_c[hit_idx] = 1'b1;
                  sel_d         = hit_idx;
                  pend_d        = 1'b1;
               end else begin
                  fault_d    = 1'b1;
                  fault_pc_d = bus.pc;
               end
            end
         end
      endcase

      if (bus.stall) begin
         if (!hold_vld_q && vld_c) begin
            hold_d     = instr_c;
            hold_vld_d = 1'b1;
         end
      end else begin
         hold_vld_d = 1'b0;
      end
   end

   // State registers. Reset aborts any outstanding fetch and drops the
   // held instruction.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_RUN;
         sel_q      <= '0;
         pend_q     <= 1'b0;
         fault_q    <= 1'b0;
         fault_pc_q <= '0;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         pend_q     <= pend_d;
         fault_q    <= fault_d;
         fault_pc_q <= fault_pc_d;
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
      end
   end

   // The enables are also forced low during the reset cycle, so that no
   // source sees a read while the controller is being cleared.
   assign bus.src_re     = reset ? '0 : re_c;
   assign bus.instr      = instr_c;
   assign bus.instr_vld  = vld_c;
   assign bus.fetch_wait = wait_c;
   assign bus.fault      = fault_q;
   assign bus.fault_pc   = fault_pc_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_ctrl
//  Self-checking bench for if_fetch_ctrl. The stimulus side drives one cycle
//  at a time. For each cycle it asks a behavioural model for the expected
//  outputs and queues them. A monitor pops one expectation per cycle on the
//  falling edge and compares it with the DUT.
// ---------------------------------------------------------------------------
module tb_if_fetch_ctrl;

   localparam int          ADDR_W  = 32;
   localparam int          DATA_W  = 32;
   localparam int          NUM_SRC = 2;
   localparam int          TAG_W   = 4;
   localparam int          TAGS    = 'h41;
   localparam logic [31:0] NOP     = 32'h0;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   if_fetch_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SRC(NUM_SRC)) bus ();

   if_fetch_ctrl #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .TAG_W(TAG_W),
      .SRC_TAGS(8'h41), .NOP_INSTR(32'h0)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   typedef struct {
      logic [1:0]  re;
      logic [31:0] instr;
      logic        vld;
      logic        fwait;
      logic        fault;
      logic [31:0] fpc;
      bit          resetCycle;
   } exp_t;

   exp_t expQ[$];
   int   compared   = 0;
   int   mismatched = 0;

   // Model view: which source owes data this cycle, whether the controller
   // is parked waiting on it, the instruction kept for a stalled pipeline,
   // and the fault pulse due this cycle.
   int          mPend    = -1;
   bit          mWait    = 1'b0;
   int          mWaitSrc = 0;
   logic [31:0] mHold[$];
   bit          mFault   = 1'b0;
   logic [31:0] mFaultPc = 32'h0;

   logic [31:0] curPc;
   bit          curStall;
   logic [1:0]  curReady;
   logic [63:0] curRdata;
   bit          curReset;
   bit          curVld;
   logic [31:0] curInstr;
   bit          curFwait;
   int          curOutst;
   bit          started = 1'b0;

   function automatic int decodeSrc(input logic [31:0] a);
      int t;
      t = int'(a >> (ADDR_W - TAG_W));
      for (int i = 0; i < NUM_SRC; i++) begin
         if (t == ((TAGS >> (i * TAG_W)) & 'hF)) return i;
      end
      return -1;
   endfunction

   function automatic logic [1:0] oneHot(input int i);
      logic [1:0] v;
      v = 2'b00;
      if (i >= 0) v[i] = 1'b1;
      return v;
   endfunction

   // Rolls the model over the clock edge that closed the previous cycle.
   task automatic modelAdvance();
      bit free;
      int m;
      int newPend;
      if (curReset) begin
         mPend    = -1;
         mWait    = 1'b0;
         mFault   = 1'b0;
         mFaultPc = 32'h0;
         mHold.delete();
         return;
      end
      free    = !mWait && !curFwait;
      m       = decodeSrc(curPc);
      newPend = (free && !curStall && m >= 0) ? m : -1;
      if (free && !curStall && m < 0) begin
         mFault   = 1'b1;
         mFaultPc = curPc;
      end else begin
         mFault = 1'b0;
      end
      if (curFwait) begin
         mWait    = 1'b1;
         mWaitSrc = curOutst;
      end else begin
         mWait = 1'b0;
      end
      if (curStall) begin
         if (mHold.size() == 0 && curVld) mHold.push_back(curInstr);
      end else begin
         mHold.delete();
      end
      mPend = newPend;
   endtask

   // Expected outputs for the cycle whose inputs were just driven.
   task automatic modelOutputs(output exp_t e);
      int outst;
      int m;
      outst  = mWait ? mWaitSrc : mPend;
      m      = decodeSrc(curPc);
      e.fwait = (outst >= 0) && !curReady[outst];
      if (mHold.size() > 0) begin
         e.instr = mHold[0];
         e.vld   = 1'b1;
      end else if (outst >= 0 && curReady[outst]) begin
         e.instr = curRdata[outst*32 +: 32];
         e.vld   = 1'b1;
      end else begin
         e.instr = NOP;
         e.vld   = 1'b0;
      end
      if (curReset) e.re = 2'b00;
      else if (outst >= 0 && (mWait || e.fwait)) e.re = oneHot(outst);
      else if (!curStall && m >= 0) e.re = oneHot(m);
      else e.re = 2'b00;
      e.fault      = mFault;
      e.fpc        = mFaultPc;
      e.resetCycle = curReset;
      curVld   = e.vld;
      curInstr = e.instr;
      curFwait = e.fwait;
      curOutst = outst;
   endtask

   // One bench cycle: advance the model across the edge, drive new inputs,
   // then queue what the DUT should show for them.
   task automatic applyStimulus(input logic [31:0] p, input bit s,
                                input logic [1:0] rdy, input logic [63:0] rd,
                                input bit rst);
      exp_t e;
      @(posedge clk);
      #1;
      if (started) modelAdvance();
      started       = 1'b1;
      bus.pc        = p;
      bus.stall     = s;
      bus.src_ready = rdy;
      bus.src_rdata = rd;
      reset         = rst;
      curPc    = p;
      curStall = s;
      curReady = rdy;
      curRdata = rd;
      curReset = rst;
      modelOutputs(e);
      expQ.push_back(e);
   endtask

   task automatic checkField(input string name, input logic [31:0] act,
                             input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, req);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      checkField("src_re", 32'(bus.src_re), 32'(e.re));
      if (!e.resetCycle) begin
         checkField("instr_vld",  32'(bus.instr_vld),  32'(e.vld));
         checkField("instr",      bus.instr,           e.instr);
         checkField("fetch_wait", 32'(bus.fetch_wait), 32'(e.fwait));
         checkField("fault",      32'(bus.fault),      32'(e.fault));
         checkField("fault_pc",   bus.fault_pc,        e.fpc);
      end
   endtask

   // Monitor: one expectation per cycle, compared mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin
      logic [31:0] p;
      logic [3:0]  t;
      int          r;
      reset         = 1'b1;
      bus.pc        = '0;
      bus.stall     = 1'b0;
      bus.src_ready = 2'b11;
      bus.src_rdata = '0;

      applyStimulus(32'h0, 1'b0, 2'b11, 64'h0, 1'b1);

      // Plain fetches from IMEM, then BIOS.
      applyStimulus(32'h1000_0000, 1'b0, 2'b11, {32'h0, 32'h0}, 1'b0);
      applyStimulus(32'h4000_0010, 1'b0, 2'b11, {32'h0, 32'h1111_0001}, 1'b0);
      applyStimulus(32'h1000_0000, 1'b0, 2'b11, {32'h2408_0001, 32'h0}, 1'b0);

      // Stall with changing source data, then release.
      applyStimulus(32'h1000_0000, 1'b1, 2'b11, {32'h0, 32'hAAAA_AAAA}, 1'b0);
      applyStimulus(32'h1000_0000, 1'b1, 2'b11, {32'h0, 32'hBBBB_BBBB}, 1'b0);
      applyStimulus(32'h1000_0000, 1'b1, 2'b11, {32'h0, 32'hCCCC_CCCC}, 1'b0);
      applyStimulus(32'h1000_0004, 1'b0, 2'b11, {32'h0, 32'hDDDD_DDDD}, 1'b0);
      applyStimulus(32'h4000_0000, 1'b0, 2'b11, {32'h0, 32'h1234_5678}, 1'b0);

      // Slow BIOS: ready low for three cycles.
      applyStimulus(32'h4000_0000, 1'b0, 2'b01, {32'h5555_0000, 32'h0}, 1'b0);
      applyStimulus(32'h4000_0000, 1'b0, 2'b01, {32'h5555_0001, 32'h0}, 1'b0);
      applyStimulus(32'h4000_0000, 1'b0, 2'b01, {32'h5555_0002, 32'h0}, 1'b0);
      applyStimulus(32'h4000_0000, 1'b0, 2'b11, {32'h5555_0003, 32'h0}, 1'b0);

      // Unmapped PC.
      applyStimulus(32'h8000_0004, 1'b0, 2'b11, 64'h0, 1'b0);
      applyStimulus(32'h1000_0008, 1'b0, 2'b11, 64'h0, 1'b0);

      // Reset in the middle of a slow-source wait.
      applyStimulus(32'h4000_0020, 1'b0, 2'b11, {32'h0, 32'h7777_7777}, 1'b0);
      applyStimulus(32'h4000_0020, 1'b0, 2'b01, 64'h0, 1'b0);
      applyStimulus(32'h4000_0020, 1'b0, 2'b01, 64'h0, 1'b1);
      applyStimulus(32'h1000_0000, 1'b0, 2'b11, 64'h0, 1'b0);
      applyStimulus(32'h1000_0004, 1'b0, 2'b11, {32'h0, 32'h9999_0001}, 1'b0);

      // Randomised traffic.
      for (int n = 0; n < 2000; n++) begin
         r = $urandom_range(0, 9);
         if (r < 4) t = 4'h1;
         else if (r < 8) t = 4'h4;
         else t = 4'($urandom);
         p = {t, 28'($urandom)};
         applyStimulus(p, ($urandom_range(0, 3) == 0),
                       {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)},
                       {32'($urandom), 32'($urandom)},
                       ($urandom_range(0, 99) == 0));
      end

      applyStimulus(32'h1000_0000, 1'b0, 2'b11, 64'h0, 1'b0);
      repeat (3) @(posedge clk);
      if (expQ.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
